// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one 1-bit full adder processes two WIDTH-bit
// operands LSB first, one bit per clock, behind a start/busy/done handshake.

module full_adder (
  input  logic A_i,
  input  logic B_i,
  input  logic C_i,
  output logic S_o,
  output logic C_o
);
  assign S_o = A_i ^ B_i ^ C_i;
  assign C_o = (A_i & B_i) | (A_i & C_i) | (B_i & C_i);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             C_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q, s_q;
  logic [WIDTH-1:0] s_sh_d;
  logic [CW-1:0]    cnt_q;
  logic             cy_q, c_q, busy_q, done_q;
  logic             fa_sum, fa_carry;

  full_adder u_fa (
    .A_i (a_sh_q[0]),
    .B_i (b_sh_q[0]),
    .C_i (cy_q),
    .S_o (fa_sum),
    .C_o (fa_carry)
  );

  // New sum bit enters at the MSB so the LSB-first result ends up in place.
  assign s_sh_d = WIDTH'({fa_sum, s_sh_q} >> 1);

  // NOTE: synchronous reset clears every register, including the shift
  // registers, so a reset mid-RUN leaves no stale partial result behind.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every register
      // sees the pre-edge values of the others regardless of statement order.
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_sh_q  <= A_i;
            b_sh_q  <= B_i;
            cy_q    <= C_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          s_sh_q <= s_sh_d;
          cy_q   <= fa_carry;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            s_q     <= s_sh_d;
            c_q     <= fa_carry;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign S_o    = s_q;
  assign C_o    = c_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances,
// directed vectors, results checked by monitors on done_o.

module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rstn;
  logic       start8, c8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] s8;
  logic       start1, a1, b1, c1;
  logic       busy1, done1, cout1;
  logic       s1;

  int n_total = 0;
  int n_pass  = 0;
  logic [8:0] exp_q8[$];
  logic [1:0] exp_q1[$];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start8), .A_i(a8), .B_i(b8), .C_i(c8),
    .busy_o(busy8), .done_o(done8), .S_o(s8), .C_o(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start1), .A_i(a1), .B_i(b1), .C_i(c1),
    .busy_o(busy1), .done_o(done1), .S_o(s1), .C_o(cout1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (exp_q8.size() == 0) check("w8_unexpected_done", 32'd1, 32'd0);
      else check("w8_result", {23'd0, cout8, s8}, {23'd0, exp_q8.pop_front()});
    end
    if (done1 === 1'b1) begin
      if (exp_q1.size() == 0) check("w1_unexpected_done", 32'd1, 32'd0);
      else check("w1_result", {30'd0, cout1, s1}, {30'd0, exp_q1.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request for one cycle; returns just after the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic expect_result);
    start8 = 1'b1; a8 = a; b8 = b; c8 = c;
    if (expect_result) exp_q8.push_back(9'(a) + 9'(b) + 9'(c));
    step();
    start8 = 1'b0; a8 = 8'hxx; b8 = 8'hxx; c8 = 1'bx;
  endtask

  // Count busy cycles until done_o appears, bounded.
  task automatic wait_done8(input string name, input int exp_busy);
    int  n = 0;
    bit  all_busy = 1'b1;
    while (done8 !== 1'b1 && n < 40) begin
      if (busy8 !== 1'b1) all_busy = 1'b0;
      n++;
      step();
    end
    check({name, "_done_seen"}, {31'd0, done8}, 32'd1);
    check({name, "_busy_cycles"}, n, exp_busy);
    check({name, "_busy_steady"}, {31'd0, all_busy}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    step(); step();
    check("reset_w8_outputs", {21'd0, busy8, done8, cout8, s8}, 32'd0);
    check("reset_w1_outputs", {28'd0, busy1, done1, cout1, s1}, 32'd0);
    rstn = 1'b1;
    step();

    // 5A + A5 = FF
    issue8(8'h5A, 8'hA5, 1'b0, 1'b1);
    wait_done8("op_5a_a5", 8);
    step();
    check("done_one_cycle", {31'd0, done8}, 32'd0);

    // FF + 01 = 1_00, then FF + FF + 1 = 1_FF
    issue8(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done8("op_ff_01", 8);
    step();
    issue8(8'hFF, 8'hFF, 1'b1, 1'b1);
    wait_done8("op_ff_ff_c", 8);
    step();

    // 03 + 04 with an ignored request in RUN cycle 3
    issue8(8'h03, 8'h04, 1'b0, 1'b1);
    step(); step();
    start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; c8 = 1'b0;
    step();
    start8 = 1'b0;
    wait_done8("op_midrun", 5);
    check("midrun_hold_result", {23'd0, cout8, s8}, 32'h007);
    for (int i = 0; i < 12; i++) step();
    check("midrun_no_restart", {30'd0, busy8, done8}, 32'd0);

    // Start held high: back-to-back 10 + 20 + 1 = 31, three times
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; c8 = 1'b1;
    for (int k = 0; k < 3; k++) exp_q8.push_back(9'h031);
    step();
    wait_done8("held_1", 8);
    step();
    wait_done8("held_2", 8);
    step();
    start8 = 1'b0;
    wait_done8("held_3", 8);
    step();
    check("held_stop", {30'd0, busy8, done8}, 32'd0);

    // 80 + 80 abandoned by reset in RUN cycle 4; S_o still holds 31 before reset
    issue8(8'h80, 8'h80, 1'b0, 1'b0);
    step(); step(); step();
    check("pre_reset_hold", {22'd0, busy8, cout8, s8}, 32'h231);
    rstn = 1'b0;
    step();
    check("midrun_reset_outputs", {21'd0, busy8, done8, cout8, s8}, 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("after_reset_idle", {30'd0, busy8, done8}, 32'd0);
    issue8(8'h80, 8'h80, 1'b0, 1'b1);
    wait_done8("op_80_80", 8);
    step();

    // WIDTH=1: 1 + 1 + 1 = 2'b11
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    exp_q1.push_back(2'b11);
    step();
    start1 = 1'b0;
    check("w1_busy", {30'd0, busy1, done1}, 32'd2);
    step();
    check("w1_done", {30'd0, busy1, done1}, 32'd1);
    step();
    check("w1_idle", {30'd0, busy1, done1}, 32'd0);

    check("w8_queue_drained", exp_q8.size(), 32'd0);
    check("w1_queue_drained", exp_q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition sequencer. It owns one `full_adder` datapath and time-multiplexes it over the bits of two `WIDTH`-bit operands, LSB first, one bit per clock. A start/busy/done handshake lets a parent block issue back-to-back multi-bit additions through a single 1-bit adder cell. It sits between operand-producing logic and the single adder instance and is the only driver of that instance's inputs.

## Interface
- `WIDTH`, default 8: operand and result width in bits, ≥1.
- `clk_i`  in  1  single clock, rising edge.
- `rstn_i`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  request; sampled only when not busy.
- `A_i`  in  `WIDTH`  operand A, sampled with an accepted `start_i`.
- `B_i`  in  `WIDTH`  operand B, sampled with an accepted `start_i`.
- `C_i`  in  1  carry-in, sampled with an accepted `start_i`.
- `busy_o`  out  1  high while a bit-serial operation is in progress.
- `done_o`  out  1  one-cycle pulse; `S_o`/`C_o` hold a new result.
- `S_o`  out  `WIDTH`  registered sum, stable between completions.
- `C_o`  out  1  registered carry-out, stable between completions.

## Operation
- Internal state:
  - operand shift registers `a_sh`, `b_sh` (`WIDTH` bits each)
  - result shift register `s_sh`
  - carry register `cy`
  - bit counter `cnt` (`$clog2(WIDTH)` bits, minimum 1)
  - FSM state
- Datapath: one `full_adder` instance.
  - Inputs: `A_i=a_sh[0]`, `B_i=b_sh[0]`, `C_i=cy`.
  - Its `S_o`/`C_o` feed `s_sh` and `cy`. No other adder logic is permitted.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if `start_i`=1, latch `A_i`→`a_sh`, `B_i`→`b_sh`, `C_i`→`cy`, `cnt`←0, go to RUN. Else stay.
  - RUN: on each edge:
    - shift `a_sh`, `b_sh` right by 1
    - `s_sh`←{fa_sum, `s_sh[WIDTH-1:1]`}
    - `cy`←fa_carry
    - `cnt`←`cnt`+1
  - RUN exit: when `cnt`==`WIDTH-1`, also load `S_o`←{fa_sum, `s_sh[WIDTH-1:1]`} and `C_o`←fa_carry, then go to DONE.
  - DONE: lasts one cycle. If `start_i`=1, accept a new operation exactly as in IDLE and go to RUN (back-to-back). Else go to IDLE.
- `start_i` in RUN is ignored and not queued. Operand inputs are don't-care outside the accepting cycle.
- Arithmetic: the result is {`C_o`,`S_o`} = `A_i`+`B_i`+`C_i`, exact modulo 2^(`WIDTH`+1). There is no overflow flag.
- `WIDTH`=1: RUN lasts one cycle; behaviour matches a registered full adder.
- Reset (`rstn_i`=0 at an edge) wins over every other event:
  - state←IDLE
  - `busy_o`=0, `done_o`=0, `S_o`=0, `C_o`=0
  - all internal registers ←0
- Reset mid-RUN abandons the operation with no `done_o` pulse and no `S_o`/`C_o` update.

## Timing
- All outputs are registered.
  - Reset values: `busy_o`=0, `done_o`=0, `S_o`=0, `C_o`=0.
  - `busy_o` = (state==RUN); `done_o` = (state==DONE).
- With `start_i` accepted at edge E0:
  - `busy_o` is high from after E0 through edge E`WIDTH` (exactly `WIDTH` cycles).
  - `S_o`/`C_o` update at edge E`WIDTH`.
  - `done_o` is high for the single cycle after E`WIDTH`.
- Latency from start edge to `done_o` is `WIDTH` cycles. Throughput is one result per `WIDTH`+1 cycles with `start_i` held high.
- `start_i` held high continuously: re-accepted in every DONE cycle, never in RUN.
- `S_o`/`C_o` hold their value through subsequent RUN phases until the next completion edge.

## Test plan
- `WIDTH`=8, A=8'h5A, B=8'hA5, C=0, 1-cycle start pulse:
  - `busy_o` high for 8 cycles, then `done_o` for 1 cycle.
  - `S_o`=8'hFF, `C_o`=0.
- A=8'hFF, B=8'h01, C=0 → `S_o`=8'h00, `C_o`=1. Then A=8'hFF, B=8'hFF, C=1 → `S_o`=8'hFF, `C_o`=1.
- Start A=8'h03, B=8'h04, C=0. At cycle 3 of RUN, assert `start_i` with A=8'hF0, B=8'h0F:
  - The mid-RUN request is ignored.
  - Result is `S_o`=8'h07, `C_o`=0, with a single `done_o` pulse.
- `start_i` held high with A=8'h10, B=8'h20, C=1:
  - `done_o` pulses every 9 cycles.
  - Each result is 8'h31, `C_o`=0.
  - `busy_o` drops only during DONE cycles.
- Complete one operation, then start A=8'h80, B=8'h80 and drive `rstn_i`=0 at RUN cycle 4:
  - All outputs are 0 on the next cycle.
  - No `done_o` pulse.
  - A new start after reset computes 8'h80+8'h80 → `S_o`=8'h00, `C_o`=1.
- `WIDTH`=1, A=1, B=1, C=1 → `busy_o` for 1 cycle, `done_o` on the next cycle, `S_o`=1, `C_o`=1.
